// File: rtl/md5_block_ctrl.sv
// Iterative MD5 compression engine: one 512-bit block per handshake, one round
// per clock, chaining value carried across blocks and returned as a digest.
module md5_block_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [127:0] dig_data,
    output logic         busy,
    output logic [5:0]   round_idx
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;
    localparam logic [5:0]  LAST = 6'(ROUNDS - 1);

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [4:0] shamt(input logic [1:0] grp, input logic [1:0] idx);
        logic [4:0] s;
        s = 5'd0;
        case (grp)
            2'd0: case (idx) 2'd0: s = 5'd7; 2'd1: s = 5'd12; 2'd2: s = 5'd17; 2'd3: s = 5'd22; endcase
            2'd1: case (idx) 2'd0: s = 5'd5; 2'd1: s = 5'd9;  2'd2: s = 5'd14; 2'd3: s = 5'd20; endcase
            2'd2: case (idx) 2'd0: s = 5'd4; 2'd1: s = 5'd11; 2'd2: s = 5'd16; 2'd3: s = 5'd23; endcase
            2'd3: case (idx) 2'd0: s = 5'd6; 2'd1: s = 5'd10; 2'd2: s = 5'd15; 2'd3: s = 5'd21; endcase
        endcase
        return s;
    endfunction

    function automatic logic [31:0] k_rom(input logic [5:0] i);
        logic [31:0] k;
        k = 32'h0;
        case (i)
            6'd0:  k = 32'hd76aa478; 6'd1:  k = 32'he8c7b756; 6'd2:  k = 32'h242070db; 6'd3:  k = 32'hc1bdceee;
            6'd4:  k = 32'hf57c0faf; 6'd5:  k = 32'h4787c62a; 6'd6:  k = 32'ha8304613; 6'd7:  k = 32'hfd469501;
            6'd8:  k = 32'h698098d8; 6'd9:  k = 32'h8b44f7af; 6'd10: k = 32'hffff5bb1; 6'd11: k = 32'h895cd7be;
            6'd12: k = 32'h6b901122; 6'd13: k = 32'hfd987193; 6'd14: k = 32'ha679438e; 6'd15: k = 32'h49b40821;
            6'd16: k = 32'hf61e2562; 6'd17: k = 32'hc040b340; 6'd18: k = 32'h265e5a51; 6'd19: k = 32'he9b6c7aa;
            6'd20: k = 32'hd62f105d; 6'd21: k = 32'h02441453; 6'd22: k = 32'hd8a1e681; 6'd23: k = 32'he7d3fbc8;
            6'd24: k = 32'h21e1cde6; 6'd25: k = 32'hc33707d6; 6'd26: k = 32'hf4d50d87; 6'd27: k = 32'h455a14ed;
            6'd28: k = 32'ha9e3e905; 6'd29: k = 32'hfcefa3f8; 6'd30: k = 32'h676f02d9; 6'd31: k = 32'h8d2a4c8a;
            6'd32: k = 32'hfffa3942; 6'd33: k = 32'h8771f681; 6'd34: k = 32'h6d9d6122; 6'd35: k = 32'hfde5380c;
            6'd36: k = 32'ha4beea44; 6'd37: k = 32'h4bdecfa9; 6'd38: k = 32'hf6bb4b60; 6'd39: k = 32'hbebfbc70;
            6'd40: k = 32'h289b7ec6; 6'd41: k = 32'heaa127fa; 6'd42: k = 32'hd4ef3085; 6'd43: k = 32'h04881d05;
            6'd44: k = 32'hd9d4d039; 6'd45: k = 32'he6db99e5; 6'd46: k = 32'h1fa27cf8; 6'd47: k = 32'hc4ac5665;
            6'd48: k = 32'hf4292244; 6'd49: k = 32'h432aff97; 6'd50: k = 32'hab9423a7; 6'd51: k = 32'hfc93a039;
            6'd52: k = 32'h655b59c3; 6'd53: k = 32'h8f0ccc92; 6'd54: k = 32'hffeff47d; 6'd55: k = 32'h85845dd1;
            6'd56: k = 32'h6fa87e4f; 6'd57: k = 32'hfe2ce6e0; 6'd58: k = 32'ha3014314; 6'd59: k = 32'h4e0811a1;
            6'd60: k = 32'hf7537e82; 6'd61: k = 32'hbd3af235; 6'd62: k = 32'h2ad7d2bb; 6'd63: k = 32'heb86d391;
        endcase
        return k;
    endfunction

    state_e            state_q, state_d;
    logic [5:0]        rnd_q, rnd_d;
    logic [31:0]       a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [31:0]       ch_a_q, ch_a_d, ch_b_q, ch_b_d, ch_c_q, ch_c_d, ch_d_q, ch_d_d;
    logic [15:0][31:0] m_q, m_d;
    logic              dig_valid_q, dig_valid_d;

    // Round datapath
    logic [31:0] f, sum, rot, b_new;
    logic [3:0]  g;
    logic [4:0]  sh;

    always_comb begin
        f = 32'h0;
        g = 4'd0;
        case (rnd_q[5:4])
            2'd0: begin
                f = (b_q & c_q) | (~b_q & d_q);
                g = rnd_q[3:0];
            end
            2'd1: begin
                f = (d_q & b_q) | (~d_q & c_q);
                g = 4'(rnd_q[3:0] * 4'd5 + 4'd1);
            end
            2'd2: begin
                f = b_q ^ c_q ^ d_q;
                g = 4'(rnd_q[3:0] * 4'd3 + 4'd5);
            end
            default: begin
                f = c_q ^ (b_q | ~d_q);
                g = 4'(rnd_q[3:0] * 4'd7);
            end
        endcase
        sh    = shamt(rnd_q[5:4], rnd_q[1:0]);
        sum   = a_q + f + k_rom(rnd_q) + m_q[g];
        rot   = (sum << sh) | (sum >> (6'd32 - {1'b0, sh}));
        b_new = b_q + rot;
    end

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        ch_a_d      = ch_a_q;
        ch_b_d      = ch_b_q;
        ch_c_d      = ch_c_q;
        ch_d_d      = ch_d_q;
        m_d         = m_q;
        dig_valid_d = dig_valid_q;
        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    // Byte 0 sits at the top of the block; MD5 words are little-endian.
                    for (int j = 0; j < 16; j++) begin
                        m_d[j] = bswap(blk_data[511-32*j -: 32]);
                    end
                    if (blk_first) begin
                        {ch_a_d, ch_b_d, ch_c_d, ch_d_d} = {IV_A, IV_B, IV_C, IV_D};
                        {a_d, b_d, c_d, d_d}             = {IV_A, IV_B, IV_C, IV_D};
                    end else begin
                        {a_d, b_d, c_d, d_d} = {ch_a_q, ch_b_q, ch_c_q, ch_d_q};
                    end
                    rnd_d   = 6'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                a_d   = d_q;
                d_d   = c_q;
                c_d   = b_q;
                b_d   = b_new;
                rnd_d = rnd_q + 6'd1;
                if (rnd_q == LAST) begin
                    ch_a_d      = ch_a_q + d_q;
                    ch_b_d      = ch_b_q + b_new;
                    ch_c_d      = ch_c_q + b_q;
                    ch_d_d      = ch_d_q + c_q;
                    rnd_d       = 6'd0;
                    dig_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (dig_ready) begin
                    dig_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rnd_q       <= 6'd0;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            c_q         <= 32'h0;
            d_q         <= 32'h0;
            ch_a_q      <= IV_A;
            ch_b_q      <= IV_B;
            ch_c_q      <= IV_C;
            ch_d_q      <= IV_D;
            m_q         <= '0;
            dig_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            ch_a_q      <= ch_a_d;
            ch_b_q      <= ch_b_d;
            ch_c_q      <= ch_c_d;
            ch_d_q      <= ch_d_d;
            m_q         <= m_d;
            dig_valid_q <= dig_valid_d;
        end
    end

    assign blk_ready = (state_q == IDLE);
    assign busy      = (state_q == ROUND);
    assign round_idx = busy ? rnd_q : 6'd0;
    assign dig_valid = dig_valid_q;
    // Digest is only driven while it is on offer; zero otherwise.
    assign dig_data  = (state_q == DONE) ?
                       {bswap(ch_a_q), bswap(ch_b_q), bswap(ch_c_q), bswap(ch_d_q)} : 128'h0;

endmodule

// File: tb/tb_md5_block_ctrl.sv
// Scoreboard bench for md5_block_ctrl: directed blocks with known MD5 digests.
module tb_md5_block_ctrl;

    logic         clock, reset_n;
    logic         blk_valid, blk_ready, blk_first;
    logic [511:0] blk_data;
    logic         dig_valid, dig_ready, busy;
    logic [127:0] dig_data;
    logic [5:0]   round_idx;

    md5_block_ctrl #(.ROUNDS(64)) dut (
        .clock(clock), .reset_n(reset_n),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_first(blk_first),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
        .busy(busy), .round_idx(round_idx)
    );

    localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] D_TWO   = 128'h8215ef0796a20bcaaae116d3876c664a;

    typedef struct {
        bit           care;
        logic [127:0] dig;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] set_b(input logic [511:0] b, input int k, input logic [7:0] v);
        logic [511:0] r;
        r = b;
        r[511-8*k -: 8] = v;
        return r;
    endfunction

    function automatic logic [511:0] str_blk(input string s);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < s.len() && i < 64; i++) r[511-8*i -: 8] = s[i];
        return r;
    endfunction

    // Monitor: every completed digest handshake consumes one scoreboard entry.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && dig_valid && dig_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_digest: got %h, no digest expected", dig_data);
            end else begin
                e = sb.pop_front();
                if (e.care) check(e.name, dig_data, e.dig);
            end
        end
    end

    task automatic send(input logic [511:0] b, input logic first, input bit push,
                        input bit care, input logic [127:0] exp, input string name);
        exp_t e;
        int t;
        t = 0;
        @(negedge clock);
        while (blk_ready !== 1'b1 && t < 300) begin
            @(negedge clock);
            t++;
        end
        check({name, " blk_ready timeout"}, 128'(t >= 300), 128'd0);
        blk_data  = b;
        blk_first = first;
        blk_valid = 1'b1;
        @(posedge clock);
        if (push) begin
            e.care = care;
            e.dig  = exp;
            e.name = name;
            sb.push_back(e);
        end
        #1;
        blk_valid = 1'b0;
        blk_data  = {16{$urandom()}};
        blk_first = ~first;
    endtask

    // Counts negedges from the accepting edge (inclusive) until dig_valid appears.
    task automatic trace(input string tag, input bit chk_rounds);
        int lat, busy_n, bad_idx;
        lat = -1;
        busy_n = 0;
        bad_idx = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (busy === 1'b1) begin
                if (round_idx !== 6'(busy_n)) bad_idx++;
                busy_n++;
            end
            if (dig_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 128'(lat), 128'd65);
        if (chk_rounds) begin
            check({tag, " busy cycles"}, 128'(busy_n), 128'd64);
            check({tag, " round_idx steps"}, 128'(bad_idx), 128'd0);
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((sb.size() != 0 || blk_ready !== 1'b1) && t < 300) begin
            @(negedge clock);
            t++;
        end
        check({tag, " drain timeout"}, 128'(t >= 300), 128'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " blk_ready"}, 128'(blk_ready), 128'd1);
        check({tag, " dig_valid"}, 128'(dig_valid), 128'd0);
        check({tag, " busy"}, 128'(busy), 128'd0);
        check({tag, " round_idx"}, 128'(round_idx), 128'd0);
        check({tag, " dig_data"}, dig_data, 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d scoreboard entries pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] blk_empty, blk_abc, blk_two1, blk_two2;
        logic [127:0] held;
        int bad, t;

        reset_n = 1'b0; blk_valid = 1'b0; blk_data = '0; blk_first = 1'b0; dig_ready = 1'b1;

        blk_empty = set_b('0, 0, 8'h80);
        blk_abc   = set_b(set_b(str_blk("abc"), 3, 8'h80), 56, 8'h18);
        blk_two1  = set_b(str_blk("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 56, 8'h80);
        blk_two2  = set_b(set_b('0, 56, 8'hc0), 57, 8'h01);

        repeat (2) @(negedge clock);
        check_idle_outputs("reset");
        reset_n = 1'b1;

        // Empty message, digest held under backpressure for 20 cycles
        dig_ready = 1'b0;
        send(blk_empty, 1'b1, 1'b1, 1'b1, D_EMPTY, "t1 empty digest");
        trace("t1", 1'b0);
        held = dig_data;
        check("t4 held dig_data", held, D_EMPTY);
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (dig_valid !== 1'b1 || dig_data !== held || blk_ready !== 1'b0) bad++;
        end
        check("t4 hold stable", 128'(bad), 128'd0);
        @(posedge clock);
        #1 dig_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("t4 release blk_ready", 128'(blk_ready), 128'd1);
        check("t4 release dig_valid", 128'(dig_valid), 128'd0);

        // "abc" with round trace
        send(blk_abc, 1'b1, 1'b1, 1'b1, D_ABC, "t2 abc digest");
        trace("t2", 1'b1);
        drain("t2");

        // Two-block message
        send(blk_two1, 1'b1, 1'b1, 1'b0, '0, "t3 blk1");
        drain("t3a");
        send(blk_two2, 1'b0, 1'b1, 1'b1, D_TWO, "t3 two-block digest");
        drain("t3b");

        // Restart mid-message discards the chain
        send(blk_two1, 1'b1, 1'b1, 1'b0, '0, "t6 blk1");
        drain("t6a");
        send(blk_abc, 1'b1, 1'b1, 1'b1, D_ABC, "t6 restart digest");
        drain("t6b");

        // Reset during round 30 with a non-IV chain pending
        send(blk_two1, 1'b1, 1'b1, 1'b0, '0, "t5 blk1");
        drain("t5a");
        send(blk_abc, 1'b0, 1'b0, 1'b0, '0, "t5 aborted");
        t = 0;
        while (round_idx !== 6'd30 && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("t5 reach round 30", 128'(t >= 100), 128'd0);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("t5 reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        send(blk_empty, 1'b0, 1'b1, 1'b1, D_EMPTY, "t5 post-reset digest");
        drain("t5b");
        repeat (80) @(negedge clock);
        check("t5 scoreboard empty", 128'(sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md5_block_ctrl.md
Name: md5_block_ctrl

Overview:
- Iterative MD5 compression controller: accepts one pre-padded 512-bit block per valid/ready handshake and sequences the 64 MD5 rounds at one round per clock.
- Maintains the 128-bit chaining state across blocks, so multi-block messages hash correctly.
- Presents the 128-bit digest through a valid/ready output handshake.
- Replaces the single-cycle, 64-round unrolled hash with a compact multi-cycle engine; it sits between the message padder (upstream) and the digest consumer (downstream).

Parameters:
- ROUNDS, 64, number of compression rounds sequenced per block (fixed by MD5; exposed only for reduced-round debug builds, legal range 16..64, multiple of 16).

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- blk_valid  in  1  upstream block available.
- blk_ready  out  1  controller can accept a block.
- blk_data  in  512  padded block; [511:504] is message byte 0.
- blk_first  in  1  sampled with the block; 1 = start a new message (chain := IV).
- dig_valid  out  1  digest available.
- dig_ready  in  1  downstream accepts digest.
- dig_data  out  128  current chaining value, byte-serialised; [127:120] = a0[7:0].
- busy  out  1  high in ROUND state.
- round_idx  out  6  current round number, 0 outside ROUND.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; blk_ready = 1; dig_valid = 0; busy = 0; round_idx = 0; dig_data = 0.
  - Chain registers = IV: a0 = 67452301, b0 = efcdab89, c0 = 98badcfe, d0 = 10325476.
  - A/B/C/D and message store = 0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - blk_ready = 1.
  - On an edge with blk_valid & blk_ready: latch M[j] = little-endian word of bytes 4j..4j+3.
  - Load A..D from IV if blk_first = 1, else from the chain registers; the chain registers are also overwritten with IV when blk_first = 1.
  - Set rnd = 0 and go to ROUND.
- ROUND:
  - blk_ready = 0; one round per edge.
  - Function select and message index g:
    - rnd 0-15: F = (B&C)|(~B&D), g = rnd.
    - rnd 16-31: F = (D&B)|(~D&C), g = (5·rnd+1) mod 16.
    - rnd 32-47: F = B^C^D, g = (3·rnd+5) mod 16.
    - rnd 48-63: F = C^(B|~D), g = 7·rnd mod 16.
  - Shift table per group: {7,12,17,22}, {5,9,14,20}, {4,11,16,23}, {6,10,15,21}, indexed by rnd[1:0].
  - K[rnd] is the standard 64-entry constant ROM.
  - Register update: A←D, D←C, C←B, B←B+rotl32(A+F+K+M[g], s).
  - All arithmetic is modulo 2^32; rotation is a true rotate.
- Round ROUNDS-1 edge:
  - Chain += the new A..D values (mod 2^32, per word).
  - dig_valid ← 1; state ← DONE.
- Latency: dig_valid rises exactly ROUNDS+1 edges after the accepting edge (65 for MD5). Throughput is one block per 66 cycles minimum.
- DONE:
  - dig_valid = 1; dig_data is stable and equals the updated chain.
  - Holds indefinitely while dig_ready = 0.
  - On dig_valid & dig_ready: dig_valid ← 0, state ← IDLE.
  - blk_ready stays 0 in DONE, so a block cannot be accepted in the same cycle as the digest.
- Every block produces a digest. For intermediate blocks the consumer discards it, but the handshake is still mandatory.
- Changes to blk_data/blk_first after acceptance are ignored.
- Reset mid-ROUND or mid-DONE: abort immediately, chain returns to IV, and no digest is produced.
- blk_first = 0 on the very first block after reset uses the reset IV, which gives the same result as blk_first = 1.

Test Plan:
1. Empty message: blk_data = 0x80 followed by 0s, blk_first = 1, dig_ready = 1 → dig_valid 65 edges after accept; dig_data = d41d8cd98f00b204e9800998ecf8427e.
2. "abc": bytes 61 62 63 80, byte 56 = 0x18, rest 0 → dig_data = 900150983cd24fb0d6963f7d28e17f72; busy high exactly 64 cycles; round_idx steps 0..63.
3. Two-block "abcdbcde…nopq" (56 bytes): block 1 with blk_first = 1, block 2 (0x80 + zeros + length 0x1c0) with blk_first = 0 → second digest = 8215ef0796a20bcaaae116d3876c664a.
4. Backpressure: hold dig_ready = 0 for 20 cycles after test 1's digest → dig_valid and dig_data stable, blk_ready = 0 throughout; release → next cycle IDLE and blk_ready = 1.
5. Reset at round 30 of "abc", then the empty-message block with blk_first = 0 → digest d41d8cd98f00b204e9800998ecf8427e (chain restored to IV, no stale digest emitted).
6. Message restart: after test 3's block 1, send "abc" with blk_first = 1 → 900150983cd24fb0d6963f7d28e17f72 (chain discarded).
